// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: walks an active-low row drive, synchronizes and
// debounces the columns, and emits one key_valid pulse with a hex code per press.
module keypad_scan_debounce #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] key_row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, cols_s;
  logic [SW-1:0] step_q, step_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    pat_q, pat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          tick;

  function automatic logic one_low(input logic [3:0] c);
    logic [3:0] n;
    n = ~c;
    return (n != 4'h0) && ((n & (n - 4'd1)) == 4'h0);
  endfunction

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [3:0] pat);
    logic [1:0] c;
    case (pat)
      4'b1110: c = 2'd0;
      4'b1101: c = 2'd1;
      4'b1011: c = 2'd2;
      default: c = 2'd3;
    endcase
    case ({r, c})
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'hE;
      4'd13:   return 4'h0;
      4'd14:   return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  assign tick = (step_q == STEP_LAST);

  // The row index doubles as the latched row while a key is being debounced or held.
  always_comb begin
    state_d = state_q;
    step_d  = tick ? '0 : step_q + 1'b1;
    row_d   = row_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low(cols_s)) begin
            pat_d   = cols_s;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (cols_s == pat_q) begin
            if (cnt_q == CNT_LAST) begin
              key_d   = decode(row_q, pat_q);
              valid_d = 1'b1;
              held_d  = 1'b1;
              cnt_d   = '0;
              state_d = HELD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d   = '0;
            row_d   = row_q + 2'd1;
            state_d = SCAN;
          end
        end
        HELD: begin
          // Counter is reused to debounce the release.
          if (cols_s == 4'hF) begin
            if (cnt_q == CNT_LAST) begin
              held_d  = 1'b0;
              cnt_d   = '0;
              row_d   = row_q + 2'd1;
              state_d = SCAN;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      cols_s  <= 4'hF;
      state_q <= SCAN;
      step_q  <= '0;
      row_q   <= 2'd0;
      pat_q   <= 4'hF;
      cnt_q   <= '0;
      key_q   <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= cols;
      cols_s  <= sync1_q;
      state_q <= state_d;
      step_q  <= step_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign key_row   = ~(4'b0001 << row_q);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce: a switch-matrix model drives the
// columns from the DUT's row drive; expected timing is hand-derived per step.
module tb_keypad_scan_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols;
  logic [3:0] key_row;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;   // bit r*4+c = switch at row r, column c closed
  int checks = 0;
  int errors = 0;
  int cyc    = 0;         // rising edges since the last reset release
  int pulse_cnt = 0;
  int dbl_cnt   = 0;
  logic prev_valid = 1'b0;

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .reset(reset), .cols(cols), .key_row(key_row),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!key_row[r]) cols = cols & ~pressed[r*4 +: 4];
  end

  always @(posedge clk) begin
    if (key_valid) pulse_cnt <= pulse_cnt + 1;
    if (key_valid && prev_valid) dbl_cnt <= dbl_cnt + 1;
    prev_valid <= key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step1();
  endtask

  initial begin
    logic [3:0] er;
    reset   = 1'b0;
    pressed = '0;
    repeat (3) @(negedge clk);
    chk("rst_row",   key_row,   4'b1110);
    chk("rst_key",   key,       4'h0);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_held",  key_held,  1'b0);
    reset = 1'b1;
    cyc   = 0;

    // T1 idle scan
    for (int n = 1; n <= 64; n++) begin
      step1();
      er = ~(4'b0001 << ((cyc / 4) % 4));
      chk("t1_row", key_row, er);
      chk("t1_valid", key_valid, 1'b0);
    end
    chk("t1_pulses", pulse_cnt, 0);

    // T2 press r1c2 -> 6
    pressed[1*4+2] = 1'b1;
    run_to(79);
    chk("t2_novalid_early", key_valid, 1'b0);
    run_to(80);
    chk("t2_valid", key_valid, 1'b1);
    chk("t2_key",   key,       4'h6);
    chk("t2_held",  key_held,  1'b1);
    chk("t2_row",   key_row,   4'b1101);
    run_to(81);
    chk("t2_valid_drop", key_valid, 1'b0);
    chk("t2_pulses", pulse_cnt, 1);
    run_to(100);
    chk("t2_row_hold",   key_row,   4'b1101);
    chk("t2_held_hold",  key_held,  1'b1);
    chk("t2_pulses_hold", pulse_cnt, 1);
    pressed = '0;
    run_to(111);
    chk("t2_held_before_rel", key_held, 1'b1);
    run_to(112);
    chk("t2_held_rel", key_held, 1'b0);
    chk("t2_row_rel",  key_row,  4'b1011);
    chk("t2_key_keep", key,      4'h6);

    // T3 bounce on r0c0, then stable -> 1
    pressed[0] = 1'b1;
    run_to(124);
    chk("t3_row_latched", key_row, 4'b1110);
    pressed[0] = 1'b0;
    run_to(128);
    chk("t3_abort_row",  key_row,  4'b1101);
    chk("t3_abort_held", key_held, 1'b0);
    pressed[0] = 1'b1;
    run_to(151);
    chk("t3_no_pulse_abort", pulse_cnt, 1);
    chk("t3_novalid_early",  key_valid, 1'b0);
    run_to(152);
    chk("t3_valid", key_valid, 1'b1);
    chk("t3_key",   key,       4'h1);
    run_to(153);
    chk("t3_pulses", pulse_cnt, 2);
    pressed[0] = 1'b0;
    run_to(163);
    chk("t3_held_before_rel", key_held, 1'b1);
    run_to(164);
    chk("t3_held_rel", key_held, 1'b0);
    chk("t3_row_rel",  key_row,  4'b1101);

    // T4 hold r3c1 (0), press/release r0c3 while held
    pressed[3*4+1] = 1'b1;
    run_to(184);
    chk("t4_valid", key_valid, 1'b1);
    chk("t4_key",   key,       4'h0);
    chk("t4_held",  key_held,  1'b1);
    run_to(188);
    pressed[0*4+3] = 1'b1;
    run_to(200);
    pressed[0*4+3] = 1'b0;
    run_to(210);
    chk("t4_pulses", pulse_cnt, 3);
    chk("t4_held_mid", key_held, 1'b1);
    chk("t4_row_mid",  key_row,  4'b0111);
    chk("t4_key_mid",  key,      4'h0);
    run_to(212);
    pressed[3*4+1] = 1'b0;
    run_to(223);
    chk("t4_held_before_rel", key_held, 1'b1);
    run_to(224);
    chk("t4_held_rel", key_held, 1'b0);
    chk("t4_row_rel",  key_row,  4'b1110);

    // T5 two columns low in row 2
    pressed[2*4+0] = 1'b1;
    pressed[2*4+1] = 1'b1;
    run_to(236);
    chk("t5_row_adv", key_row, 4'b0111);
    run_to(260);
    chk("t5_pulses", pulse_cnt, 3);
    chk("t5_row_end", key_row, 4'b1101);
    chk("t5_held",   key_held, 1'b0);
    pressed = '0;

    // T6a reset mid-DEBOUNCE on r1c0
    pressed[1*4+0] = 1'b1;
    run_to(265);
    chk("t6a_row_latched", key_row, 4'b1101);
    #2 reset = 1'b0;
    #1;
    chk("t6a_row",   key_row,   4'b1110);
    chk("t6a_valid", key_valid, 1'b0);
    chk("t6a_held",  key_held,  1'b0);
    chk("t6a_key",   key,       4'h0);
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc   = 0;

    // T6b reset mid-HELD on r2c3 -> C
    pressed[2*4+3] = 1'b1;
    run_to(20);
    chk("t6b_valid", key_valid, 1'b1);
    chk("t6b_key",   key,       4'hC);
    run_to(24);
    chk("t6b_held", key_held, 1'b1);
    chk("t6b_row",  key_row,  4'b1011);
    #2 reset = 1'b0;
    #1;
    chk("t6b_rst_key",   key,       4'h0);
    chk("t6b_rst_held",  key_held,  1'b0);
    chk("t6b_rst_row",   key_row,   4'b1110);
    chk("t6b_rst_valid", key_valid, 1'b0);
    pressed = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cyc   = 0;
    run_to(40);
    chk("t6b_pulses", pulse_cnt, 4);
    chk("t6b_valid_after", key_valid, 1'b0);
    chk("t6b_held_after",  key_held,  1'b0);
    chk("t6b_row_after",   key_row,   4'b1011);
    chk("no_double_pulse", dbl_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
